// File: rtl/axil_reg_if_pkg.sv
// Shared constants for the AXI-lite register-interface bridges:
// AXI response codes and the read-side FSM encoding.
package axil_reg_if_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ACCESS = 1'b1;

  typedef enum logic [0:0] {
    StIdle   = ST_IDLE,
    StAccess = ST_ACCESS
  } rd_state_e;

endpackage

// File: rtl/axil_reg_if_rd_pipe_if.sv
// AXI-lite read channel (AR + R) bundle with master/slave views.
interface axil_reg_if_rd_pipe_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_reg_if_rd_resp_fifo.sv
// Synchronous response FIFO with async active-low reset; head entry is read
// straight out of register storage so the consumer sees registered data.
module axil_reg_if_rd_resp_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    pop_ok   = pop && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/axil_reg_if_rd_pipe.sv
// AXI-lite read slave bridged onto a simple register bus, with per-access
// timeout and an R-channel response FIFO that decouples the register bus.
module axil_reg_if_rd_pipe
  import axil_reg_if_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT         = 4,
  parameter logic [1:0]  TIMEOUT_RESP    = 2'b10,
  parameter int unsigned RESP_FIFO_DEPTH = 2,
  parameter bit          ALIGN_ADDR      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axil_reg_if_rd_pipe_if.slave  s_axil,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr,
  output logic [2:0]            reg_rd_prot,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_rd_wait,
  input  logic                  reg_rd_ack,
  input  logic                  reg_rd_err,
  output logic                  timeout_evt
);

  localparam int unsigned TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CW     = $clog2(RESP_FIFO_DEPTH) + 1;
  localparam int unsigned FW     = DATA_WIDTH + 2;
  localparam logic [TW-1:0] TMO_LOAD = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TMO_EN = (TIMEOUT != 0);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
      ALIGN_ADDR ? ~ADDR_WIDTH'(STRB_WIDTH - 1) : '1;

  rd_state_e             state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            prot_q, prot_d;
  logic                  arready_q, arready_d;
  logic                  tmo_q, tmo_d;

  logic                  ar_hs;
  logic                  push, pop;
  logic [FW-1:0]         push_data;
  logic [FW-1:0]         head_data;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count, count_nxt;

  assign ar_hs = s_axil.arvalid && arready_q;
  assign pop   = !fifo_empty && s_axil.rready;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    addr_d    = addr_q;
    prot_d    = prot_q;
    push      = 1'b0;
    push_data = {DATA_WIDTH'(0), RESP_OKAY};
    tmo_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ar_hs) begin
          addr_d  = s_axil.araddr & ALIGN_MASK;
          prot_d  = s_axil.arprot;
          timer_d = TMO_LOAD;
          state_d = StAccess;
        end
      end
      StAccess: begin
        // Ack beats a simultaneous expiry so a late-but-valid read still wins.
        if (reg_rd_ack) begin
          push      = 1'b1;
          push_data = {reg_rd_data, reg_rd_err ? RESP_SLVERR : RESP_OKAY};
          state_d   = StIdle;
        end else if (TMO_EN && (timer_q == '0)) begin
          push      = 1'b1;
          push_data = {DATA_WIDTH'(0), TIMEOUT_RESP};
          tmo_d     = 1'b1;
          state_d   = StIdle;
        end else if (TMO_EN && !reg_rd_wait) begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // arready is registered, so look ahead at next-cycle state and occupancy.
    count_nxt = fifo_count + CW'(push) - CW'(pop);
    arready_d = (state_d == StIdle) && (count_nxt < CW'(RESP_FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      addr_q    <= '0;
      prot_q    <= '0;
      arready_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      addr_q    <= addr_d;
      prot_q    <= prot_d;
      arready_q <= arready_d;
      tmo_q     <= tmo_d;
    end
  end

  axil_reg_if_rd_resp_fifo #(
    .WIDTH (FW),
    .DEPTH (RESP_FIFO_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_data (head_data)
  );

  assign s_axil.arready = arready_q;
  assign s_axil.rvalid  = !fifo_empty;
  assign s_axil.rdata   = head_data[FW-1:2];
  assign s_axil.rresp   = head_data[1:0];

  assign reg_rd_addr = addr_q;
  assign reg_rd_prot = prot_q;
  assign reg_rd_en   = (state_q == StAccess);
  assign timeout_evt = tmo_q;

endmodule

// File: tb/tb_axil_reg_if_rd_pipe.sv
// Bench for axil_reg_if_rd_pipe: directed scenarios plus random reads, all
// scored against a transaction-level model (busy flag + expected R queue).
module tb_axil_reg_if_rd_pipe;

  localparam int unsigned TMO   = 4;
  localparam int unsigned DEPTH = 2;
  localparam logic [1:0]  TMO_RESP = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] reg_rd_addr;
  logic [2:0]  reg_rd_prot;
  logic        reg_rd_en;
  logic [31:0] reg_rd_data;
  logic        reg_rd_wait;
  logic        reg_rd_ack;
  logic        reg_rd_err;
  logic        timeout_evt;

  axil_reg_if_rd_pipe_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axil_reg_if_rd_pipe #(
    .DATA_WIDTH      (32),
    .ADDR_WIDTH      (32),
    .TIMEOUT         (TMO),
    .TIMEOUT_RESP    (TMO_RESP),
    .RESP_FIFO_DEPTH (DEPTH),
    .ALIGN_ADDR      (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_axil      (bus.slave),
    .reg_rd_addr (reg_rd_addr),
    .reg_rd_prot (reg_rd_prot),
    .reg_rd_en   (reg_rd_en),
    .reg_rd_data (reg_rd_data),
    .reg_rd_wait (reg_rd_wait),
    .reg_rd_ack  (reg_rd_ack),
    .reg_rd_err  (reg_rd_err),
    .timeout_evt (timeout_evt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [33:0] exp_q [$];
  bit          busy;
  int          nw;
  logic [31:0] exp_addr;
  logic [2:0]  exp_prot;
  bit          exp_arready;
  bit          rnd_rready;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score the cycle about to close, advance, then check outputs.
  task automatic step();
    logic [33:0] h;
    bit tmo_e;
    bit hs;
    tmo_e = 1'b0;
    hs    = bus.arvalid && exp_arready;
    check("reg_rd_en", reg_rd_en, busy);
    if (busy) begin
      check("reg_rd_addr", reg_rd_addr, exp_addr);
      check("reg_rd_prot", reg_rd_prot, exp_prot);
    end
    if (exp_q.size() != 0 && bus.rready) begin
      h = exp_q.pop_front();
      check("rdata", bus.rdata, h[33:2]);
      check("rresp", bus.rresp, h[1:0]);
    end
    if (busy) begin
      if (reg_rd_ack) begin
        exp_q.push_back({reg_rd_data, reg_rd_err ? 2'b10 : 2'b00});
        busy = 1'b0;
      end else if (nw == TMO - 1) begin
        exp_q.push_back({32'h0, TMO_RESP});
        tmo_e = 1'b1;
        busy  = 1'b0;
      end else if (!reg_rd_wait) begin
        nw++;
      end
    end else if (hs) begin
      busy     = 1'b1;
      nw       = 0;
      exp_addr = (bus.araddr / 4) * 4;
      exp_prot = bus.arprot;
    end
    @(posedge clk);
    #1;
    reg_rd_ack = 1'b0;
    reg_rd_err = 1'b0;
    if (hs) bus.arvalid = 1'b0;
    if (rnd_rready) bus.rready = 1'($urandom_range(0, 1));
    exp_arready = !busy && (exp_q.size() < DEPTH);
    check("timeout_evt", timeout_evt, tmo_e);
    check("arready", bus.arready, exp_arready);
    check("rvalid", bus.rvalid, exp_q.size() != 0);
  endtask

  task automatic issue_ar(input logic [31:0] a, input logic [2:0] p);
    int n;
    bus.araddr  = a;
    bus.arprot  = p;
    bus.arvalid = 1'b1;
    n = 0;
    while (bus.arvalid && n < 40) begin
      step();
      n++;
    end
    check("ar_accepted", bus.arvalid, 1'b0);
    bus.arvalid = 1'b0;
  endtask

  task automatic ack_now(input logic [31:0] d, input logic e);
    reg_rd_data = d;
    reg_rd_ack  = 1'b1;
    reg_rd_err  = e;
    step();
  endtask

  task automatic drain();
    int n;
    rnd_rready = 1'b0;
    bus.rready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check("drained", exp_q.size(), 0);
    bus.rready = 1'b0;
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    reg_rd_data = '0; reg_rd_wait = 1'b0; reg_rd_ack = 1'b0; reg_rd_err = 1'b0;
    busy = 1'b0; nw = 0; exp_arready = 1'b0; rnd_rready = 1'b0;
    exp_addr = '0; exp_prot = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_arready", bus.arready, 1'b0);
    check("rst_rvalid", bus.rvalid, 1'b0);
    check("rst_en", reg_rd_en, 1'b0);
    check("rst_tmo", timeout_evt, 1'b0);
    check("rst_addr", reg_rd_addr, 32'h0);
    check("rst_prot", reg_rd_prot, 3'h0);
    rst_n = 1'b1;
    step();

    // Basic read: aligned address, rvalid two cycles after AR.
    issue_ar(32'h0000_0013, 3'h5);
    check("basic_en", reg_rd_en, 1'b1);
    check("basic_addr", reg_rd_addr, 32'h10);
    ack_now(32'hDEAD_BEEF, 1'b0);
    check("basic_rvalid", bus.rvalid, 1'b1);
    check("basic_rdata", bus.rdata, 32'hDEAD_BEEF);
    check("basic_rresp", bus.rresp, 2'b00);
    drain();

    // Error ack.
    issue_ar(32'h0000_0104, 3'h0);
    ack_now(32'h0000_1234, 1'b1);
    check("err_rresp", bus.rresp, 2'b10);
    check("err_rdata", bus.rdata, 32'h1234);
    check("err_tmo", timeout_evt, 1'b0);
    drain();

    // Timeout: no ack, wait low -> en held exactly TMO cycles.
    issue_ar(32'h0000_0200, 3'h1);
    cnt = 0;
    while (reg_rd_en && cnt < 20) begin
      step();
      cnt++;
    end
    check("tmo_en_cycles", cnt, TMO);
    check("tmo_pulse", timeout_evt, 1'b1);
    check("tmo_rresp", bus.rresp, TMO_RESP);
    check("tmo_rdata", bus.rdata, 32'h0);
    step();
    check("tmo_pulse_end", timeout_evt, 1'b0);
    drain();

    // Long wait then ack: no timeout.
    issue_ar(32'h0000_0300, 3'h2);
    reg_rd_wait = 1'b1;
    repeat (10) step();
    reg_rd_wait = 1'b0;
    ack_now(32'hCAFE_0001, 1'b0);
    check("wait_rresp", bus.rresp, 2'b00);
    drain();

    // Ack on the expiry cycle: ack wins.
    issue_ar(32'h0000_0400, 3'h3);
    repeat (TMO - 1) step();
    ack_now(32'h5A5A_A5A5, 1'b0);
    check("coll_tmo", timeout_evt, 1'b0);
    check("coll_rdata", bus.rdata, 32'h5A5A_A5A5);
    check("coll_rresp", bus.rresp, 2'b00);
    drain();

    // Backpressure: two reads fill the FIFO, third waits for a pop.
    bus.rready = 1'b0;
    issue_ar(32'h0000_0500, 3'h0);
    ack_now(32'h1111_1111, 1'b0);
    issue_ar(32'h0000_0504, 3'h0);
    ack_now(32'h2222_2222, 1'b0);
    bus.araddr = 32'h0000_0508; bus.arprot = 3'h4; bus.arvalid = 1'b1;
    repeat (3) step();
    check("bp_arready_low", bus.arready, 1'b0);
    check("bp_en_low", reg_rd_en, 1'b0);
    bus.rready = 1'b1;
    step();
    check("bp_arready_back", bus.arready, 1'b1);
    bus.rready = 1'b0;
    step();
    check("bp_third_en", reg_rd_en, 1'b1);
    ack_now(32'h3333_3333, 1'b0);
    drain();

    // Reset mid-access with one FIFO entry.
    issue_ar(32'h0000_0600, 3'h0);
    ack_now(32'h4444_4444, 1'b0);
    issue_ar(32'h0000_0604, 3'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", bus.rvalid, 1'b0);
    check("mid_rst_en", reg_rd_en, 1'b0);
    check("mid_rst_arready", bus.arready, 1'b0);
    exp_q.delete();
    busy = 1'b0; exp_arready = 1'b0;
    bus.arvalid = 1'b0; reg_rd_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    issue_ar(32'h0000_0707, 3'h6);
    ack_now(32'h7777_0707, 1'b0);
    drain();

    // Random reads against the model with random rready and wait.
    rnd_rready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int n;
      issue_ar($urandom, 3'($urandom_range(0, 7)));
      n = 0;
      while (busy && n < 60) begin
        reg_rd_wait = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 2) == 0) begin
          reg_rd_ack  = 1'b1;
          reg_rd_err  = 1'($urandom_range(0, 1));
          reg_rd_data = $urandom;
        end
        step();
        n++;
      end
      reg_rd_wait = 1'b0;
      check("rand_done", busy, 1'b0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
